// File: rtl/gate_test_pkg.sv
// ============================================================================
// Module   : gate_test_pkg
// Brief    : Shared state encoding and truth-table constants for the gate
//            vector sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam int NUM_VECTORS = 4;

  // Bit index is the vector {a,b}; bit 3 is a=1,b=1.
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/hold_timer.sv
// ============================================================================
// Module   : hold_timer
// Brief    : Counts enabled cycles and flags when HOLD_CYCLES-1 is reached.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int c_cnt_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(HOLD_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/gate_vector_sequencer.sv
// ============================================================================
// Module   : gate_vector_sequencer
// Brief    : Sweeps all four {a,b} vectors into a two-input gate and checks y.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int                     HOLD_CYCLES = 10,
  parameter logic [NUM_VECTORS-1:0] EXP_TABLE   = TT_AND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [1:0] c_last_vec = 2'(NUM_VECTORS - 1);

  seq_state_t r_state;
  seq_state_t w_state_next;

  logic       w_accept;
  logic       w_sample;
  logic       w_timer_en;
  logic       w_expired;
  logic       w_mismatch;
  logic [1:0] w_vec_next;
  logic [2:0] w_err_next;

  logic [1:0] r_vec;
  logic       r_a, r_b, r_busy, r_done, r_pass;
  logic [2:0] r_err_count;
  logic [3:0] r_fail_vec;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept | w_sample),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_timer_en   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = APPLY;
        end
      end
      APPLY: begin
        if (w_expired) w_state_next = SAMPLE;
        else           w_timer_en   = 1'b1;
      end
      SAMPLE: begin
        w_sample     = 1'b1;
        w_state_next = (r_vec == c_last_vec) ? DONE : APPLY;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_mismatch = (y_in != EXP_TABLE[r_vec]);
  assign w_err_next = r_err_count + {2'b00, w_mismatch};
  assign w_vec_next = r_vec + 2'd1;

  // Outputs are registered so the gate inputs change only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_vec  <= '0;
    end else if (w_accept) begin
      r_vec       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_vec  <= '0;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err_count       <= w_err_next;
        r_fail_vec[r_vec] <= 1'b1;
      end
      if (r_vec == c_last_vec) begin
        r_a    <= 1'b0;
        r_b    <= 1'b0;
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_err_next == 3'd0);
      end else begin
        r_vec <= w_vec_next;
        r_a   <= w_vec_next[1];
        r_b   <= w_vec_next[0];
      end
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule

`default_nettype wire
